fpga_tile_gen2: RTL
===================

// Module: fpga_tile_gen2
// PURPOSE
//  Second-generation logic tile with NUM_LE K-input LUT elements and an input/output crossbar to the routing bus.
//  Replaces the bit-serial CRAM chain with a word-parallel, double-buffered configuration port.
//  Words load into a shadow store and reach the fabric only on an explicit commit, so live reconfiguration never glitches.
//  Word-serial readback of the active configuration is supported.
//  Sits inside the fabric array; the configuration controller drives cfg_*/rb_*.
// PARAMETERS
//  BUS_WIDTH  8  routing bus width (bus_in/bus_out)
//  NUM_LE     4  LUT elements per tile
//  LE_INPUTS  4  LUT inputs K; LUT holds 2**K bits
//  CFG_WORD   8  configuration word width
//  derived: SELW=$clog2(BUS_WIDTH+NUM_LE); LEB=2**K+K*SELW+1
//           CFG_BITS=NUM_LE*LEB+BUS_WIDTH*SELW; WORDS=ceil(CFG_BITS/CFG_WORD) (defaults: 4,33,164,21)
// PORTS
//  clk         in   1          single clock, all state rising-edge
//  rst         in   1          asynchronous, active-high reset
//  fab_en      in   1          LE register update enable
//  bus_in      in   BUS_WIDTH  routing bus into tile
//  bus_out     out  BUS_WIDTH  routing bus out of tile
//  cfg_data    in   CFG_WORD   configuration word
//  cfg_valid   in   1          cfg_data valid
//  cfg_ready   out  1          tile accepts a word this cycle
//  cfg_commit  in   1          pulse: copy shadow to active
//  cfg_clear   in   1          pulse: abandon shadow load
//  cfg_done    out  1          an active configuration is in force
//  cfg_err     out  1          sticky: commit while not FULL
//  rb_start    in   1          pulse: begin readback
//  rb_data     out  CFG_WORD   readback word
//  rb_valid    out  1          rb_data valid
// BEHAVIOUR
//  Config vector, LSB first:
//   LE i at offset i*LEB: LUT[2**K], then sel0..sel(K-1) (SELW each), then reg bit.
//   bus_out selects at NUM_LE*LEB: osel j (SELW each).
//  Word n carries vector bits [n*CFG_WORD +: CFG_WORD]. Pad bits above CFG_BITS in the last word are ignored on load and read back as 0.
//  Source index s:
//   s<BUS_WIDTH selects bus_in[s].
//   s<BUS_WIDTH+NUM_LE selects LE index s-BUS_WIDTH.
//   Otherwise selects constant 0.
//  LE inputs use LE registered outputs le_q for feedback, so there are no combinational loops; osel uses le_out.
//  LUT address = {in[K-1],...,in[0]}. le_out[i] = reg ? le_q[i] : lut_comb[i].
//  le_q[i] <= lut_comb[i] when fab_en.
//  bus_out[j] = cfg_done ? source(osel j) : 0. Fully combinational from bus_in/le_q/active config.
//  FSM states: IDLE, LOAD, FULL, READBACK.
//   IDLE: cfg_ready=1. An accepted word (valid&ready) goes to shadow[cnt], cnt++, state -> LOAD, or -> FULL if WORDS==1.
//   LOAD: cfg_ready=1. Accept words. When word WORDS-1 is accepted -> FULL.
//   FULL: cfg_ready=0; valid is ignored. On cfg_commit:
//     - active<=shadow and LE regs cleared to 0 on the same edge
//     - cfg_done<=1, cnt<=0, -> IDLE
//     - new config drives bus_out the cycle after the commit edge
//   READBACK: entered from IDLE on rb_start with cfg_done=1.
//     - rb_valid=1 for WORDS consecutive cycles starting the cycle after rb_start
//     - word 0 first, from active config; no backpressure
//     - cfg_ready=0; then -> IDLE
//  cfg_commit in IDLE or LOAD: ignored, cfg_err<=1; active config unchanged.
//  cfg_clear in LOAD or FULL: cnt<=0, -> IDLE; active config and cfg_done unchanged.
//  rb_start outside IDLE, or with cfg_done=0: ignored.
//  Priority on the same cycle: cfg_clear > cfg_commit > cfg_valid.
//  Fabric runs unaffected during load and readback.
//  Reset (any time, incl. mid-load or mid-readback):
//   - state IDLE, cnt 0, shadow and active all 0, le_q 0
//   - cfg_done 0, cfg_err 0, rb_valid 0, rb_data 0
//   - bus_out 0, cfg_ready 1
// TESTING
//  1 rst pulse mid-load after 10 words -> bus_out=0, cfg_done=0, cfg_ready=1, cnt 0; 21 new words then required before FULL.
//  2 Load LE0 LUT=16'h8000, sel0..3=0..3, reg=0, osel0=8, other osel=15; commit; bus_in=8'h0F -> bus_out=8'h01; bus_in=8'h07 -> 8'h00.
//  3 LE1 LUT=16'h5555 (NOT in0), sel0=9, reg=1, osel1=9, fab_en=1 -> bus_out[1] toggles 0,1,0,1 per cycle; fab_en=0 holds.
//  4 Commit after 20 words -> cfg_err=1, cfg_done unchanged. 21st word -> cfg_ready=0; 22nd cfg_valid ignored.
//  5 rb_start after test 2 -> 21 rb_valid cycles echoing loaded words; word20 bits[7:4]=0; load with cfg_valid=1 and cfg_ready=0 ignored.
//  6 cfg_clear+cfg_commit same cycle in FULL -> IDLE, active unchanged, cfg_err=0.

Source files
------------

// File: rtl/fpga_tile_gen2_if.sv
// fpga_tile_gen2_if: configuration load/commit and readback port of the logic tile
interface fpga_tile_gen2_if #(
   parameter int CFG_WORD = 8
);
   logic [CFG_WORD-1:0] cfg_data;
   logic                cfg_valid;
   logic                cfg_ready;
   logic                cfg_commit;
   logic                cfg_clear;
   logic                cfg_done;
   logic                cfg_err;
   logic                rb_start;
   logic [CFG_WORD-1:0] rb_data;
   logic                rb_valid;
   modport master (
      output cfg_data, cfg_valid, cfg_commit, cfg_clear, rb_start,
      input  cfg_ready, cfg_done, cfg_err, rb_data, rb_valid
   );
   modport slave (
      input  cfg_data, cfg_valid, cfg_commit, cfg_clear, rb_start,
      output cfg_ready, cfg_done, cfg_err, rb_data, rb_valid
   );
endinterface

// File: rtl/fpga_tile_gen2.sv
// fpga_tile_gen2: LUT tile with routing crossbar and double-buffered word-parallel configuration
module fpga_tile_gen2 #(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_LE    = 4,
   parameter int LE_INPUTS = 4,
   parameter int CFG_WORD  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fab_en,
   input  logic [BUS_WIDTH-1:0] bus_in,
   output logic [BUS_WIDTH-1:0] bus_out,
   fpga_tile_gen2_if.slave      cfg
);
   localparam int SELW     = $clog2(BUS_WIDTH + NUM_LE);
   localparam int LUTW     = 2 ** LE_INPUTS;
   localparam int LEB      = LUTW + LE_INPUTS * SELW + 1;
   localparam int CFG_BITS = NUM_LE * LEB + BUS_WIDTH * SELW;
   localparam int WORDS    = (CFG_BITS + CFG_WORD - 1) / CFG_WORD;
   localparam int TOT      = WORDS * CFG_WORD;
   localparam int CNTW     = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, FULL, READBACK} state_t;

   state_t            state, state_nx;
   logic [CNTW-1:0]   cnt;
   logic [TOT-1:0]    shadow, active, vmask;
   logic [NUM_LE-1:0] le_q, lut_comb, le_out;
   logic [2**SELW-1:0] src_q, src_o;
   logic              accept, commit_ok, commit_bad, clear_ok, rb_go, rb_more, rb_last;

   always_comb begin
      clear_ok      = cfg.cfg_clear && (state == LOAD || state == FULL);
      commit_ok     = state == FULL && cfg.cfg_commit && !cfg.cfg_clear;
      commit_bad    = (state == IDLE || state == LOAD) && cfg.cfg_commit && !cfg.cfg_clear;
      rb_go         = state == IDLE && cfg.rb_start && cfg.cfg_done;
      rb_last       = state == READBACK && cnt == CNTW'(WORDS);
      rb_more       = state == READBACK && !rb_last;
      cfg.cfg_ready = state == IDLE || state == LOAD;
      accept        = cfg.cfg_valid && cfg.cfg_ready && !cfg.cfg_clear && !cfg.cfg_commit && !rb_go;
   end

   always_comb begin
      state_nx = state;
      if (state == READBACK)
         state_nx = rb_last ? IDLE : READBACK;
      else if (clear_ok || commit_ok)
         state_nx = IDLE;
      else if (rb_go)
         state_nx = READBACK;
      else if (accept)
         state_nx = cnt == CNTW'(WORDS - 1) ? FULL : LOAD;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   // pad bits above CFG_BITS never reach the active store, so readback shows them as 0
   always_comb
      for (int b = 0; b < TOT; b++)
         vmask[b] = b < CFG_BITS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         shadow       <= '0;
         active       <= '0;
         le_q         <= '0;
         cfg.cfg_done <= 1'b0;
         cfg.cfg_err  <= 1'b0;
         cfg.rb_valid <= 1'b0;
         cfg.rb_data  <= '0;
      end else begin
         if (commit_ok) begin
            active       <= shadow & vmask;
            le_q         <= '0;
            cfg.cfg_done <= 1'b1;
         end else if (fab_en)
            le_q <= lut_comb;
         if (commit_bad)
            cfg.cfg_err <= 1'b1;
         if (accept)
            shadow[cnt*CFG_WORD +: CFG_WORD] <= cfg.cfg_data;
         if (state == READBACK)
            cnt <= rb_last ? '0 : cnt + 1'b1;
         else if (clear_ok || commit_ok)
            cnt <= '0;
         else if (rb_go)
            cnt <= CNTW'(1);
         else if (accept)
            cnt <= cnt + 1'b1;
         cfg.rb_valid <= rb_go || rb_more;
         cfg.rb_data  <= rb_go ? active[0 +: CFG_WORD] :
                         rb_more ? active[cnt*CFG_WORD +: CFG_WORD] : '0;
      end
   end

   // LE inputs see only registered LE outputs, which keeps the fabric loop-free
   always_comb begin
      src_q = '0;
      src_q[BUS_WIDTH-1:0] = bus_in;
      src_q[BUS_WIDTH +: NUM_LE] = le_q;
   end

   always_comb begin
      src_o = '0;
      src_o[BUS_WIDTH-1:0] = bus_in;
      src_o[BUS_WIDTH +: NUM_LE] = le_out;
   end

   for (genvar i = 0; i < NUM_LE; i++) begin : g_le
      logic [LE_INPUTS-1:0] addr;
      logic [LUTW-1:0]      lut;
      always_comb
         for (int k = 0; k < LE_INPUTS; k++)
            addr[k] = src_q[active[i*LEB + LUTW + k*SELW +: SELW]];
      assign lut         = active[i*LEB +: LUTW];
      assign lut_comb[i] = lut[addr];
      assign le_out[i]   = active[i*LEB + LUTW + LE_INPUTS*SELW] ? le_q[i] : lut_comb[i];
   end

   for (genvar j = 0; j < BUS_WIDTH; j++) begin : g_out
      assign bus_out[j] = cfg.cfg_done ? src_o[active[NUM_LE*LEB + j*SELW +: SELW]] : 1'b0;
   end
endmodule
